// File: rtl/seq_detect_mod3_if.sv
// rtl/seq_detect_mod3_if.sv - serial bit stream in, divisibility-by-3 status out
interface seq_detect_mod3_if #(
    parameter int CNT_W = 8
);
    logic             data;
    logic             success;
    logic [1:0]       remainder;
    logic [CNT_W-1:0] bit_cnt;

    // Stream source: drives the serial bit, observes detector status
    modport master (
        output data,
        input  success,
        input  remainder,
        input  bit_cnt
    );

    // Detector: consumes the serial bit, reports status
    modport slave (
        input  data,
        output success,
        output remainder,
        output bit_cnt
    );
endinterface

// File: rtl/seq_detect_mod3.sv
// rtl/seq_detect_mod3.sv - MSB-first serial mod-3 detector; SEQ_DETECT_MOD3_MEALY_EN selects combinational success
module seq_detect_mod3 #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,   // active-high asynchronous reset despite its name
    seq_detect_mod3_if.slave  bus
);

    // Only V mod 3 is held, so the stream length is unbounded
    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifndef SEQ_DETECT_MOD3_MEALY_EN
    logic             success_q, success_d;
`endif

    // State register: remainder, first-bit flag and saturating bit counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= R0;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next remainder is (2r + d) mod 3; counter sticks at all-ones
    always_comb begin
        state_d = state_q;
        seen_d  = 1'b1;
        cnt_d   = cnt_q;
        case (state_q)
            R0:      state_d = bus.data ? R1 : R0;
            R1:      state_d = bus.data ? R0 : R2;
            R2:      state_d = bus.data ? R2 : R1;
            default: state_d = R0;
        endcase
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef SEQ_DETECT_MOD3_MEALY_EN
    logic [2:0] mealy_sum;

    // Same-cycle answer: 2r + d lies in 0..5, divisible by 3 only at 0 or 3
    always_comb begin
        mealy_sum   = {state_q, bus.data};
        bus.success = !rst_n && ((mealy_sum == 3'd0) || (mealy_sum == 3'd3));
    end
`else
    // Registered answer: the seen flag keeps success low until a bit has arrived
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            success_q <= 1'b0;
        end else begin
            success_q <= success_d;
        end
    end

    // success follows the next-state values so it lines up with the flops above
    always_comb begin
        success_d = seen_d && (state_d == R0);
    end

    assign bus.success = success_q;
`endif

    assign bus.remainder = state_q;
    assign bus.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_seq_detect_mod3.sv
// tb/tb_seq_detect_mod3.sv - randomized and directed checks of seq_detect_mod3 against a bit-queue model
module tb_seq_detect_mod3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    seq_detect_mod3_if #(.CNT_W(8)) bus8 ();
    seq_detect_mod3_if #(.CNT_W(2)) bus2 ();

    seq_detect_mod3 #(.CNT_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    seq_detect_mod3 #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;
    bit q[$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // V mod 3 from the stored bits: 2^k is 1 mod 3 for even k, 2 for odd k
    function automatic int ref_mod3();
        int s = 0;
        int n = q.size();
        for (int i = 0; i < n; i++) begin
            if (((n - 1 - i) % 2) == 0) s += int'(q[i]);
            else                        s += 2 * int'(q[i]);
        end
        return s % 3;
    endfunction

    function automatic int sat(input int n, input int w);
        int lim = (1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    task automatic check_post();
        int r = ref_mod3();
        check("rem8", int'(bus8.remainder), r);
        check("rem2", int'(bus2.remainder), r);
        check("cnt8", int'(bus8.bit_cnt), sat(q.size(), 8));
        check("cnt2", int'(bus2.bit_cnt), sat(q.size(), 2));
`ifndef SEQ_DETECT_MOD3_MEALY_EN
        check("succ8", int'(bus8.success), int'(q.size() > 0 && r == 0));
        check("succ2", int'(bus2.success), int'(q.size() > 0 && r == 0));
`endif
    endtask

    // Called shortly after a rising edge; returns 1 ns after the next one
    task automatic send_bit(input bit b);
        int e;
        bus8.data = b;
        bus2.data = b;
        #3;
`ifdef SEQ_DETECT_MOD3_MEALY_EN
        q.push_back(b);
        e = int'(ref_mod3() == 0);
        void'(q.pop_back());
`else
        e = int'(q.size() > 0 && ref_mod3() == 0);
`endif
        check("pre_succ8", int'(bus8.success), e);
        check("pre_succ2", int'(bus2.success), e);
        @(posedge clk);
        #1;
        q.push_back(b);
        check_post();
    endtask

    // Pulse reset between edges and confirm outputs clear without a clock edge
    task automatic pulse_reset();
        #1 rst_n = 1'b1;
        #2;
        check("rst_rem8", int'(bus8.remainder), 0);
        check("rst_succ8", int'(bus8.success), 0);
        check("rst_cnt8", int'(bus8.bit_cnt), 0);
        check("rst_rem2", int'(bus2.remainder), 0);
        check("rst_succ2", int'(bus2.success), 0);
        check("rst_cnt2", int'(bus2.bit_cnt), 0);
        #1 rst_n = 1'b0;
        q.delete();
    endtask

    initial begin
        bus8.data = 1'b0;
        bus2.data = 1'b0;
        @(posedge clk);
        #1;
        pulse_reset();

        // Released, no bit sampled yet
`ifndef SEQ_DETECT_MOD3_MEALY_EN
        check("idle_succ", int'(bus8.success), 0);
`endif
        send_bit(1'b1);
        send_bit(1'b1);
        check("v3_rem", int'(bus8.remainder), 0);
        check("v3_cnt", int'(bus8.bit_cnt), 2);
`ifndef SEQ_DETECT_MOD3_MEALY_EN
        check("v3_succ", int'(bus8.success), 1);
`endif

        @(posedge clk);
        #1;
        pulse_reset();
        send_bit(1'b1); check("v1_rem", int'(bus8.remainder), 1);
        send_bit(1'b0); check("v2_rem", int'(bus8.remainder), 2);
        send_bit(1'b1); check("v5_rem", int'(bus8.remainder), 2);
        send_bit(1'b1); check("v11_rem", int'(bus8.remainder), 2);
        send_bit(1'b0); check("v22_rem", int'(bus8.remainder), 1);

        pulse_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
`ifndef SEQ_DETECT_MOD3_MEALY_EN
        check("v6_succ", int'(bus8.success), 1);
`endif
        send_bit(1'b1);
        check("v13_rem", int'(bus8.remainder), 1);
`ifndef SEQ_DETECT_MOD3_MEALY_EN
        check("v13_succ", int'(bus8.success), 0);
`endif

        pulse_reset();
        send_bit(1'b0);
        check("z_cnt", int'(bus8.bit_cnt), 1);
`ifndef SEQ_DETECT_MOD3_MEALY_EN
        check("z_succ", int'(bus8.success), 1);
`endif

        pulse_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("v18_cnt2", int'(bus2.bit_cnt), 3);
        check("v18_rem2", int'(bus2.remainder), 0);
`ifndef SEQ_DETECT_MOD3_MEALY_EN
        check("v18_succ2", int'(bus2.success), 1);
`endif

        // Long stream without reset drives the 8-bit counter into saturation
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            send_bit(1'($urandom_range(0, 1)));
        end
        check("sat_cnt8", int'(bus8.bit_cnt), 255);

        // Random bits with zero bursts and occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulse_reset();
            end
            if ($urandom_range(0, 9) == 0) begin
                send_bit(1'b0);
            end else begin
                send_bit(1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
